// File: rtl/alu_srca_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_srca_if
// Brief    : Bundle of operand candidates, forwarding inputs, valid/ready
//            handshake, flush and error-tracking signals for the ALU source-A
//            stage. The master drives the stage and the slave is the stage.
// Revision : 1.0  initial release
// ============================================================================
interface alu_srca_if #(
    parameter int XLEN     = 32,
    parameter int NSRC     = 4,
    parameter int SEL_W    = $clog2(NSRC),
    parameter int ERRCNT_W = 8
);
    // Operand candidates and selection
    logic [NSRC*XLEN-1:0] srcs;
    logic [SEL_W-1:0]     srcA_SEL;

    // Forwarding from later pipeline stages
    logic                 fwd_mem_hit;
    logic [XLEN-1:0]      fwd_mem_data;
    logic                 fwd_wb_hit;
    logic [XLEN-1:0]      fwd_wb_data;

    // Upstream handshake
    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;

    // Downstream handshake and payload
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      ALU_srcA;
    logic                 illegal_sel;

    // Error tracking
    logic                 err_clr;
    logic                 err_sticky;
    logic [ERRCNT_W-1:0]  err_count;

    modport master (
        output srcs, srcA_SEL,
        output fwd_mem_hit, fwd_mem_data, fwd_wb_hit, fwd_wb_data,
        output in_valid, flush, out_ready, err_clr,
        input  in_ready, out_valid, ALU_srcA, illegal_sel,
        input  err_sticky, err_count
    );

    modport slave (
        input  srcs, srcA_SEL,
        input  fwd_mem_hit, fwd_mem_data, fwd_wb_hit, fwd_wb_data,
        input  in_valid, flush, out_ready, err_clr,
        output in_ready, out_valid, ALU_srcA, illegal_sel,
        output err_sticky, err_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_srca_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_srca_stage
// Brief    : Registered ALU source-A operand stage. Picks one of NSRC
//            candidates (slot 0 = rs1 with MEM/WB forwarding), holds it in a
//            one-entry valid/ready register and tracks illegal selects.
// Revision : 1.0  initial release
// ============================================================================
module alu_srca_stage #(
    parameter int          XLEN     = 32,
    parameter int          NSRC     = 4,
    parameter int          SEL_W    = $clog2(NSRC),
    parameter logic [31:0] FILL     = 32'hDEADBEEF,
    parameter int          ERRCNT_W = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    alu_srca_if.slave  bus
);
    // Fill pattern resized to the operand width (truncate or zero-extend)
    localparam logic [XLEN-1:0]     FILL_X   = XLEN'(FILL);
    localparam logic [SEL_W:0]      NSRC_C   = (SEL_W+1)'(NSRC);
    localparam logic [ERRCNT_W-1:0] CNT_MAX  = '1;

    // ------------------------------------------------------------------
    // Candidate slots unpacked from the flat bus
    // ------------------------------------------------------------------
    logic [XLEN-1:0] slot [NSRC];

    genvar gk;
    generate
        for (gk = 0; gk < NSRC; gk++) begin : g_slot
            assign slot[gk] = bus.srcs[gk*XLEN +: XLEN];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Combinational operand selection
    // ------------------------------------------------------------------
    logic            w_sel_legal;
    logic            w_sel_zero;
    logic [XLEN-1:0] w_slot_val;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_operand;

    // Legal means the select addresses an existing slot; only reachable
    // as false when NSRC is not a power of two.
    assign w_sel_legal = ({1'b0, bus.srcA_SEL} < NSRC_C);
    assign w_sel_zero  = (bus.srcA_SEL == '0);

    // Plain slot mux over the legal range
    always_comb begin
        w_slot_val = '0;
        for (int k = 0; k < NSRC; k++) begin
            if ({1'b0, bus.srcA_SEL} == (SEL_W+1)'(k)) begin
                w_slot_val = slot[k];
            end
        end
    end

    // rs1 forwarding: the younger MEM result beats the older WB result
    always_comb begin
        w_rs1_fwd = slot[0];
        if (bus.fwd_mem_hit) begin
            w_rs1_fwd = bus.fwd_mem_data;
        end else if (bus.fwd_wb_hit) begin
            w_rs1_fwd = bus.fwd_wb_data;
        end
    end

    // Final operand: forwarding applies to slot 0 only, fill for illegal
    always_comb begin
        w_operand = FILL_X;
        if (w_sel_legal) begin
            w_operand = w_sel_zero ? w_rs1_fwd : w_slot_val;
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic            r_out_valid;
    logic [XLEN-1:0] r_operand;
    logic            r_illegal;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_accept_illegal;

    // The register frees up when empty or being drained this cycle
    assign w_in_ready       = !r_out_valid || bus.out_ready;
    assign w_accept         = bus.in_valid && w_in_ready && !bus.flush;
    assign w_accept_illegal = w_accept && !w_sel_legal;

    // Pipeline register: flush beats load, load beats drain, else hold
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_valid <= 1'b0;
            r_operand   <= '0;
            r_illegal   <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_operand   <= w_operand;
            r_illegal   <= !w_sel_legal;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Error tracking
    // ------------------------------------------------------------------
    logic                r_err_sticky;
    logic [ERRCNT_W-1:0] r_err_count;

    // Sticky flag and saturating counter; a same-cycle illegal accept
    // overrides the clear so the event is never lost.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (w_accept_illegal) begin
            r_err_sticky <= 1'b1;
            if (bus.err_clr) begin
                r_err_count <= ERRCNT_W'(1);
            end else if (r_err_count != CNT_MAX) begin
                r_err_count <= r_err_count + ERRCNT_W'(1);
            end
        end else if (bus.err_clr) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.ALU_srcA    = r_operand;
    assign bus.illegal_sel = r_illegal;
    assign bus.err_sticky  = r_err_sticky;
    assign bus.err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_srca_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_srca_stage
// Brief    : Directed self-checking bench for alu_srca_stage, using one
//            NSRC=4 instance and one NSRC=3 instance (for illegal selects).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_srca_stage;
    logic CLK;
    logic RST_N;

    int passed;
    int total;

    alu_srca_if #(.XLEN(32), .NSRC(4), .ERRCNT_W(8)) b4 ();
    alu_srca_if #(.XLEN(32), .NSRC(3), .ERRCNT_W(8)) b3 ();

    alu_srca_stage #(.XLEN(32), .NSRC(4), .FILL(32'hDEADBEEF), .ERRCNT_W(8)) u4 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (b4.slave)
    );

    alu_srca_stage #(.XLEN(32), .NSRC(3), .FILL(32'hDEADBEEF), .ERRCNT_W(8)) u3 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (b3.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One comparison with pass/fail accounting
    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    endtask

    // Advance one clock; outputs settle 1 time unit after the edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        RST_N  = 1'b0;

        b4.srcs = '0; b4.srcA_SEL = '0;
        b4.fwd_mem_hit = 1'b0; b4.fwd_mem_data = '0;
        b4.fwd_wb_hit  = 1'b0; b4.fwd_wb_data  = '0;
        b4.in_valid = 1'b0; b4.flush = 1'b0; b4.out_ready = 1'b0; b4.err_clr = 1'b0;

        b3.srcs = '0; b3.srcA_SEL = '0;
        b3.fwd_mem_hit = 1'b0; b3.fwd_mem_data = '0;
        b3.fwd_wb_hit  = 1'b0; b3.fwd_wb_data  = '0;
        b3.in_valid = 1'b0; b3.flush = 1'b0; b3.out_ready = 1'b0; b3.err_clr = 1'b0;

        // Reset state
        step(); step();
        chk("rst_out_valid",  {63'd0, b4.out_valid},   64'd0);
        chk("rst_alu_srca",   {32'd0, b4.ALU_srcA},    64'd0);
        chk("rst_illegal",    {63'd0, b4.illegal_sel}, 64'd0);
        chk("rst_sticky",     {63'd0, b4.err_sticky},  64'd0);
        chk("rst_count",      {56'd0, b4.err_count},   64'd0);
        chk("rst_in_ready",   {63'd0, b4.in_ready},    64'd1);
        RST_N = 1'b1;
        step();

        // 1. Plain slot select
        b4.srcs = {32'h4444_0003, 32'h3333_0002, 32'h1234_5678, 32'h0000_0001};
        b4.srcA_SEL = 2'd1; b4.in_valid = 1'b1; b4.out_ready = 1'b1;
        step();
        chk("t1_valid",   {63'd0, b4.out_valid},   64'd1);
        chk("t1_data",    {32'd0, b4.ALU_srcA},    64'h1234_5678);
        chk("t1_illegal", {63'd0, b4.illegal_sel}, 64'd0);

        // 2. Forwarding priority on slot 0
        b4.srcA_SEL = 2'd0;
        b4.fwd_wb_hit = 1'b1;  b4.fwd_wb_data  = 32'd2;
        b4.fwd_mem_hit = 1'b1; b4.fwd_mem_data = 32'd3;
        step();
        chk("t2_mem_wins", {32'd0, b4.ALU_srcA}, 64'd3);
        b4.fwd_mem_hit = 1'b0;
        step();
        chk("t2_wb",       {32'd0, b4.ALU_srcA}, 64'd2);
        b4.fwd_wb_hit = 1'b0;
        step();
        chk("t2_slot0",    {32'd0, b4.ALU_srcA}, 64'd1);

        // Forward hits must not affect non-zero slots
        b4.fwd_mem_hit = 1'b1; b4.srcA_SEL = 2'd3;
        step();
        chk("t2_nofwd_slot3", {32'd0, b4.ALU_srcA}, 64'h4444_0003);
        b4.fwd_mem_hit = 1'b0;

        // 3. Backpressure: held value frozen, new data waits
        b4.srcs[2*32 +: 32] = 32'hAAAA_0001;
        b4.srcA_SEL = 2'd2; b4.out_ready = 1'b0;
        #1;
        chk("t3_in_ready_low", {63'd0, b4.in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_frozen_data",  {32'd0, b4.ALU_srcA},  64'h4444_0003);
            chk("t3_frozen_valid", {63'd0, b4.out_valid}, 64'd1);
        end
        b4.out_ready = 1'b1;
        #1;
        chk("t3_in_ready_high", {63'd0, b4.in_ready}, 64'd1);
        step();
        chk("t3_new_data",  {32'd0, b4.ALU_srcA},  64'hAAAA_0001);
        chk("t3_new_valid", {63'd0, b4.out_valid}, 64'd1);
        b4.in_valid = 1'b0;
        step();
        chk("t3_drained",   {63'd0, b4.out_valid}, 64'd0);
        chk("t3_data_kept", {32'd0, b4.ALU_srcA},  64'hAAAA_0001);

        // Flush while holding under backpressure drops the operand
        b4.in_valid = 1'b1; b4.srcA_SEL = 2'd1;
        step();
        b4.out_ready = 1'b0; b4.in_valid = 1'b0; b4.flush = 1'b1;
        step();
        chk("t3_flush_hold", {63'd0, b4.out_valid}, 64'd0);
        b4.flush = 1'b0; b4.out_ready = 1'b1;

        // 4. Illegal select on the NSRC=3 build, then saturation
        b3.srcs = {32'h0000_0C0C, 32'h0000_0B0B, 32'h0000_0A0A};
        b3.srcA_SEL = 2'd3; b3.in_valid = 1'b1; b3.out_ready = 1'b1;
        step();
        chk("t4_fill",    {32'd0, b3.ALU_srcA},    64'hDEAD_BEEF);
        chk("t4_illegal", {63'd0, b3.illegal_sel}, 64'd1);
        chk("t4_sticky",  {63'd0, b3.err_sticky},  64'd1);
        chk("t4_count1",  {56'd0, b3.err_count},   64'd1);
        for (int i = 0; i < 299; i++) step();
        chk("t4_count_sat", {56'd0, b3.err_count}, 64'd255);
        b3.srcA_SEL = 2'd2;
        step();
        chk("t4_legal_data",    {32'd0, b3.ALU_srcA},    64'h0000_0C0C);
        chk("t4_legal_illegal", {63'd0, b3.illegal_sel}, 64'd0);
        chk("t4_count_hold",    {56'd0, b3.err_count},   64'd255);

        // 5. Clear, then flush blocking an illegal accept
        b3.in_valid = 1'b0; b3.err_clr = 1'b1;
        step();
        chk("t5_clr_count",  {56'd0, b3.err_count},  64'd0);
        chk("t5_clr_sticky", {63'd0, b3.err_sticky}, 64'd0);
        b3.err_clr = 1'b0; b3.flush = 1'b1; b3.in_valid = 1'b1; b3.srcA_SEL = 2'd3;
        step();
        chk("t5_flush_valid",  {63'd0, b3.out_valid},  64'd0);
        chk("t5_flush_count",  {56'd0, b3.err_count},  64'd0);
        chk("t5_flush_sticky", {63'd0, b3.err_sticky}, 64'd0);
        b3.flush = 1'b0;
        step();
        step();
        chk("t5_count2", {56'd0, b3.err_count}, 64'd2);
        b3.err_clr = 1'b1;
        step();
        chk("t5_clr_vs_accept_count",  {56'd0, b3.err_count},  64'd1);
        chk("t5_clr_vs_accept_sticky", {63'd0, b3.err_sticky}, 64'd1);
        b3.err_clr = 1'b0;

        // 6. Asynchronous reset mid-stream
        b4.in_valid = 1'b1; b4.srcA_SEL = 2'd1;
        step();
        chk("t6_pre_valid", {63'd0, b4.out_valid}, 64'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t6_async_valid", {63'd0, b4.out_valid},  64'd0);
        chk("t6_async_data",  {32'd0, b4.ALU_srcA},   64'd0);
        chk("t6_async_count", {56'd0, b3.err_count},  64'd0);
        chk("t6_async_ill",   {63'd0, b3.illegal_sel}, 64'd0);
        step();
        RST_N = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
